// File: rtl/fixed_dot3.sv
// fixed_dot3: signed fixed-point 3-component dot product built on one shared multiplier over three cycles.
// Optional macro FIXED_DOT3_SAT_EN saturates the rescaled result; the default build wraps it to WIDTH bits.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef Q_BITS
`define Q_BITS 16
`endif

module fixed_dot3 #(
  parameter int WIDTH  = `WIDTH,
  parameter int Q_BITS = `Q_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ax,
  input  logic [WIDTH-1:0] ay,
  input  logic [WIDTH-1:0] az,
  input  logic [WIDTH-1:0] bx,
  input  logic [WIDTH-1:0] by,
  input  logic [WIDTH-1:0] bz,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int ACC_W  = 2 * WIDTH + 2;

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, ACC, DONE} state_t;

  state_t                    state_reg;
  logic                      accept;
  logic [WIDTH-1:0]          a_in  [3];
  logic [WIDTH-1:0]          b_in  [3];
  logic [WIDTH-1:0]          a_op  [3];
  logic [WIDTH-1:0]          b_op  [3];
  logic [WIDTH-1:0]          mul_a;
  logic [WIDTH-1:0]          mul_b;
  logic [PROD_W-1:0]         prod_next;
  logic [PROD_W-1:0]         prod_reg;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_reg;
  logic [WIDTH-1:0]          result_next;

  assign a_in[0] = ax;
  assign a_in[1] = ay;
  assign a_in[2] = az;
  assign b_in[0] = bx;
  assign b_in[1] = by;
  assign b_in[2] = bz;

  // A new op is taken when idle or in the final cycle of the previous op.
  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_opnd
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (accept) begin
          a_reg <= a_in[gi];
          b_reg <= b_in[gi];
        end
      end

      assign a_op[gi] = a_reg;
      assign b_op[gi] = b_reg;
    end
  endgenerate

  always_comb begin
    mul_a = a_op[0];
    mul_b = b_op[0];
    case (state_reg)
      MUL1: begin
        mul_a = a_op[1];
        mul_b = b_op[1];
      end
      MUL2: begin
        mul_a = a_op[2];
        mul_b = b_op[2];
      end
      default: ;
    endcase
  end

  // Sign-extending both operands keeps the low PROD_W bits of the product exact for signed inputs.
  assign prod_next = {{WIDTH{mul_a[WIDTH-1]}}, mul_a} * {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
  assign prod_ext  = {{2{prod_reg[PROD_W-1]}}, prod_reg};

`ifdef FIXED_DOT3_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] scaled;

  assign scaled = acc_reg >>> Q_BITS;

  always_comb begin
    result_next = scaled[WIDTH-1:0];
    if (scaled > SAT_MAX) begin
      result_next = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (scaled < SAT_MIN) begin
      result_next = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  // Wrapped rescale is just the Q-aligned slice of the accumulator.
  assign result_next = acc_reg[WIDTH+Q_BITS-1:Q_BITS];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      valid     <= 1'b0;
      result    <= '0;
      prod_reg  <= '0;
      acc_reg   <= '0;
    end else begin
      valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= MUL0;
            busy      <= 1'b1;
          end
        end
        MUL0: begin
          prod_reg  <= prod_next;
          state_reg <= MUL1;
        end
        MUL1: begin
          prod_reg  <= prod_next;
          acc_reg   <= prod_ext;
          state_reg <= MUL2;
        end
        MUL2: begin
          prod_reg  <= prod_next;
          acc_reg   <= acc_reg + prod_ext;
          state_reg <= ACC;
        end
        ACC: begin
          acc_reg   <= acc_reg + prod_ext;
          state_reg <= DONE;
        end
        DONE: begin
          result <= result_next;
          valid  <= 1'b1;
          if (accept) begin
            state_reg <= MUL0;
            busy      <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_dot3.sv
// tb_fixed_dot3: random and directed stimulus for fixed_dot3, checked against an arithmetic reference model.
// Honours FIXED_DOT3_SAT_EN the same way the design does.
module tb_fixed_dot3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ax = '0, ay = '0, az = '0, bx = '0, by = '0, bz = '0;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic signed [127:0] MAXV = 128'sd2147483647;
  localparam logic signed [127:0] MINV = -128'sd2147483648;

`ifdef FIXED_DOT3_SAT_EN
  localparam logic [31:0] OVF_POS = 32'h7FFFFFFF;
  localparam logic [31:0] OVF_NEG = 32'h80000000;
`else
  localparam logic [31:0] OVF_POS = 32'h38800000;
  localparam logic [31:0] OVF_NEG = 32'hC7800000;
`endif

  always #5 clk = ~clk;

  fixed_dot3 #(.WIDTH(32), .Q_BITS(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ax     (ax),
    .ay     (ay),
    .az     (az),
    .bx     (bx),
    .by     (by),
    .bz     (bz),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact dot product, floor-shifted by 16, then saturated or wrapped to 32 bits.
  function automatic logic [31:0] ref_dot(input logic [31:0] a0, a1, a2, b0, b1, b2);
    logic signed [127:0] s;
    s = 0;
    s = s + (longint'($signed(a0)) * longint'($signed(b0)));
    s = s + (longint'($signed(a1)) * longint'($signed(b1)));
    s = s + (longint'($signed(a2)) * longint'($signed(b2)));
    s = s >>> 16;
`ifdef FIXED_DOT3_SAT_EN
    if (s > MAXV) return 32'h7FFFFFFF;
    if (s < MINV) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  // Cycle-level expectation: an op accepted at edge n completes at edge n+5.
  bit          m_inflight = 1'b0;
  bit          m_done_now;
  bit          m_exp_valid;
  int          m_edge = 0;
  int          m_acc_edge = 0;
  int          valid_cnt = 0;
  logic [31:0] m_pending = '0;
  logic [31:0] m_exp_result = '0;

  initial begin
    forever begin
      @(posedge clk);
      m_edge++;
      m_exp_valid = 1'b0;
      if (rst) begin
        m_inflight   = 1'b0;
        m_exp_result = '0;
      end else begin
        m_done_now = m_inflight && (m_edge == m_acc_edge + 5);
        if (m_done_now) begin
          m_exp_valid  = 1'b1;
          m_exp_result = m_pending;
        end
        if (start && (!m_inflight || m_done_now)) begin
          m_inflight = 1'b1;
          m_acc_edge = m_edge;
          m_pending  = ref_dot(ax, ay, az, bx, by, bz);
        end else if (m_done_now) begin
          m_inflight = 1'b0;
        end
      end
      #1;
      if (valid) valid_cnt++;
      check_eq("valid", {31'b0, valid}, {31'b0, m_exp_valid});
      check_eq("busy", {31'b0, busy}, {31'b0, m_inflight});
      check_eq("result", result, m_exp_result);
    end
  end

  task automatic set_ops(input logic [31:0] a0, a1, a2, b0, b1, b2);
    ax = a0; ay = a1; az = a2;
    bx = b0; by = b1; bz = b2;
  endtask

  task automatic rand_ops();
    set_ops($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  // One op from idle; afterwards we sit just past the completing edge.
  task automatic dir_op(input string tag, input logic [31:0] a0, a1, a2, b0, b1, b2,
                        input logic [31:0] exp);
    @(negedge clk);
    set_ops(a0, a1, a2, b0, b1, b2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rand_ops();
    repeat (5) @(negedge clk);
    check_eq(tag, result, exp);
    $display("op %s: result %h expected %h", tag, result, exp);
  endtask

  int cnt0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_busy", {31'b0, busy}, 32'd0);
    check_eq("reset_valid", {31'b0, valid}, 32'd0);
    check_eq("reset_result", result, 32'd0);

    dir_op("basic", 32'h00010000, 32'h00020000, 32'h00030000,
           32'h00040000, 32'h00050000, 32'h00060000, 32'h00200000);
    dir_op("neg", 32'hFFFE8000, 0, 0, 32'h00020000, 0, 0, 32'hFFFD0000);
    dir_op("floor", 32'hFFFFFFFF, 0, 0, 32'h00000001, 0, 0, 32'hFFFFFFFF);
    dir_op("tiny", 32'h00000001, 0, 0, 32'h00000001, 0, 0, 32'h00000000);
    dir_op("ovf_pos", 32'h00C80000, 32'h00C80000, 0, 32'h00C80000, 32'h00C80000, 0, OVF_POS);
    dir_op("ovf_neg", 32'hFF380000, 32'hFF380000, 0, 32'h00C80000, 32'h00C80000, 0, OVF_NEG);

    // Start held high with operands changing every cycle.
    @(negedge clk);
    cnt0 = valid_cnt;
    start = 1'b1;
    rand_ops();
    repeat (40) begin
      @(negedge clk);
      rand_ops();
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("hold_start_ops", valid_cnt - cnt0, 32'd8);
    $display("hold start: %0d results expected 8", valid_cnt - cnt0);

    // Reset two edges into an op.
    @(negedge clk);
    cnt0 = valid_cnt;
    set_ops(32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 32'h00050000, 32'h00060000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("abort_valid_cnt", valid_cnt - cnt0, 32'd0);
    check_eq("abort_result", result, 32'd0);
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    $display("abort: %0d results result %h busy %0d", valid_cnt - cnt0, result, busy);
    dir_op("after_abort", 32'h00010000, 32'h00020000, 32'h00030000,
           32'h00040000, 32'h00050000, 32'h00060000, 32'h00200000);

    // Random traffic with occasional resets and mixed-magnitude operands.
    repeat (1500) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 0) begin
        rand_ops();
      end else begin
        set_ops($urandom_range(0, 32'h0003FFFF) - 32'h00020000,
                $urandom_range(0, 32'h0003FFFF) - 32'h00020000,
                $urandom_range(0, 32'h0003FFFF) - 32'h00020000,
                $urandom_range(0, 32'h0003FFFF) - 32'h00020000,
                $urandom_range(0, 32'h0003FFFF) - 32'h00020000,
                $urandom_range(0, 32'h0003FFFF) - 32'h00020000);
      end
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fixed_dot3.md
Name: fixed_dot3

Overview:
- Sequenced 3-component fixed-point dot product, a·b = ax·bx + ay·by + az·bz.
- Sits directly downstream of the single-cycle fixed-point multiplier stage in the math datapath, in the same signed Q(WIDTH-Q_BITS).Q_BITS format.
- Time-multiplexes one internal multiplier over three cycles, accumulates the products at full precision, then rescales once.
- Feeds ray/plane and shading arithmetic that needs dot products with a single rounding step.

Parameters:
- WIDTH, default global `WIDTH (32): operand and result width, signed two's complement.
- Q_BITS, default global `Q_BITS (16): fractional bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled on a rising edge.
- ax, ay, az  in  WIDTH each  signed vector a components.
- bx, by, bz  in  WIDTH each  signed vector b components.
- busy  out  1  high while an operation is in flight.
- valid  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  WIDTH  signed Q-format dot product.

Behaviour:
- Reset (rst=1 at an edge): FSM goes to IDLE; busy=0, valid=0, result=0; operand, product and accumulator registers are cleared.
- States: IDLE, MUL0, MUL1, MUL2, ACC, DONE. busy=1 in every state except IDLE.
- E0, an edge where start=1 and state is IDLE or DONE:
  - latch all six operands; go to MUL0.
  - Operand inputs are don't-care after E0.
- E1: prod <= ax·bx (full 2·WIDTH signed); go to MUL1.
- E2: prod <= ay·by; acc <= sext(prod); go to MUL2.
- E3: prod <= az·bz; acc <= acc + sext(prod); go to ACC.
- E4: acc <= acc + sext(prod); go to DONE.
- E5: result <= scaled(acc); valid <= 1; go to IDLE.
  - valid is high for exactly the cycle after E5.
  - Latency: 5 edges from the start edge to valid.
- result holds its value until the next valid or a reset.
- Accumulator width is 2·WIDTH+2 bits, signed; it cannot overflow for any inputs.
- scaled(acc) = acc >>> Q_BITS (arithmetic shift, floor toward -inf, no rounding), then reduced to WIDTH bits (see optional feature).
- start while busy=1 (MUL0..DONE before E5) is ignored; there is no queueing.
- start at E5 (state DONE) is accepted: throughput is 1 op per 5 cycles.
  - At E5 the new operands are latched, state goes to MUL0, and valid still pulses for the previous op.
- Reset mid-operation: the op is aborted and no valid is ever produced for it; the next start behaves as from power-up.
- rst has priority over start in the same edge.

Optional Feature:
- Macro: FIXED_DOT3_SAT_EN.
- Defined: if scaled(acc) > 2^(WIDTH-1)-1, result = 0x7FF..F; if < -2^(WIDTH-1), result = 0x800..0; otherwise the low WIDTH bits.
- Undefined: result = scaled(acc)[WIDTH-1:0] (wrap), i.e. acc bits [WIDTH+Q_BITS-1:Q_BITS], matching the multiplier slice convention.

Test Plan:
(All values Q16.16, WIDTH=32.)
- Basic: a=(1.0,2.0,3.0)=(0x00010000,0x00020000,0x00030000), b=(4.0,5.0,6.0) -> result=0x00200000 (32.0); valid single pulse exactly 5 edges after the start edge; busy high for those 5 cycles.
- Sign/floor: a=(-1.5,0,0)=(0xFFFE8000,0,0), b=(2.0,0,0) -> 0xFFFD0000. Then a=(0xFFFFFFFF,0,0), b=(0x00000001,0,0) -> 0xFFFFFFFF (floor); a=(1,0,0), b=(1,0,0) -> 0x00000000.
- Overflow: a=b=(200.0,200.0,0) (true sum 80000.0) -> 0x38800000 without FIXED_DOT3_SAT_EN; 0x7FFFFFFF with it. Same test with a=(-200.0,-200.0,0) -> 0x80000000 when saturated.
- Handshake: hold start=1 continuously with changing operands -> ops are accepted only at E0, E5, E10 …; each valid carries the operands latched 5 edges earlier; operand changes mid-op do not affect the result.
- Reset mid-op: start, assert rst at E2 for 1 cycle -> valid never pulses, result=0, busy=0; a following basic op returns 0x00200000 at the normal latency.
